instr_mem_loader: RTL and testbench

Writer side of the instruction-memory interface. The CPU fetch path only reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and assembles 32-bit big-endian words.
- Issues one write per word into the instruction RAM write port.
- Holds the CPU in reset until the image is loaded and its checksum passes.

---
 rtl/instr_mem_loader_pkg.sv | 14 +
 rtl/instr_mem_loader_word_assembler.sv | 31 +++
 rtl/instr_mem_loader.sv | 92 +++++++++
 tb/tb_instr_mem_loader.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/instr_mem_loader_pkg.sv
// instr_mem_loader_pkg: shared state encoding and stream-format constants
package instr_mem_loader_pkg;
   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_CHECK,
      S_DONE,
      S_ERR
   } state_e;
   localparam int LEN_BYTES  = 2;
   localparam int WORD_BYTES = 4;
endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// word_assembler: packs a big-endian byte stream into 32-bit words
module word_assembler
   import instr_mem_loader_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic        word_done_o,
   output logic [31:0] word_o
);
   logic [1:0]  cnt_q, cnt_d;
   logic [23:0] sh_q, sh_d;
   // the 4th byte bypasses the shift register so the word is ready on its accepting edge
   always_comb begin
      word_done_o = byte_en_i & (cnt_q == 2'(WORD_BYTES - 1));
      word_o      = {sh_q, byte_i};
      cnt_d       = clr_i ? '0 : byte_en_i ? cnt_q + 2'd1 : cnt_q;
      sh_d        = clr_i ? '0 : byte_en_i ? {sh_q[15:0], byte_i} : sh_q;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         sh_q  <= '0;
      end else begin
         cnt_q <= cnt_d;
         sh_q  <= sh_d;
      end
   end
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: fills instruction RAM from a length-prefixed, XOR-checked byte stream
module instr_mem_loader
   import instr_mem_loader_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   output logic              byte_ready_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [31:0]       wr_data_o,
   output logic              cpu_rst_o,
   output logic              done_o,
   output logic              err_o
);
   state_e            state_q, state_d;
   logic [15:0]       len_q, len_d, widx_q, widx_d, n_len;
   logic [7:0]        csum_q, csum_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d, word;
   logic              acc, restart, word_done, last_word;

   assign byte_ready_o = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
   assign acc          = byte_valid_i & byte_ready_o;
   assign restart      = start_i & (state_q inside {S_IDLE, S_DONE, S_ERR});
   assign n_len        = {len_q[15:8], byte_data_i};
   assign last_word    = widx_q == len_q - 16'd1;
   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign done_o       = state_q == S_DONE;
   assign err_o        = state_q == S_ERR;
   assign cpu_rst_o    = state_q != S_DONE;

   word_assembler u_asm (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .clr_i       (restart),
      .byte_en_i   (acc & (state_q == S_DATA)),
      .byte_i      (byte_data_i),
      .word_done_o (word_done),
      .word_o      (word)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERR: if (start_i) state_d = S_LEN_HI;
         S_LEN_HI: if (acc) state_d = S_LEN_LO;
         S_LEN_LO: if (acc) state_d = n_len > 16'(MAX_WORDS) ? S_ERR : n_len == '0 ? S_CHECK : S_DATA;
         S_DATA:   if (word_done && last_word) state_d = S_CHECK;
         S_CHECK:  if (acc) state_d = byte_data_i == csum_q ? S_DONE : S_ERR;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      len_d     = (acc && state_q == S_LEN_HI) ? {byte_data_i, 8'h00} :
                  (acc && state_q == S_LEN_LO) ? n_len : len_q;
      widx_d    = restart ? '0 : word_done ? widx_q + 16'd1 : widx_q;
      csum_d    = restart ? '0 : (acc && state_q == S_DATA) ? csum_q ^ byte_data_i : csum_q;
      wr_en_d   = word_done;
      wr_addr_d = word_done ? ADDR_W'({widx_q, 2'b00}) : wr_addr_q;
      wr_data_d = word_done ? word : wr_data_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         len_q     <= '0;
         widx_q    <= '0;
         csum_q    <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         widx_q    <= widx_d;
         csum_q    <= csum_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized scoreboard bench for the instruction-memory loader
module tb_instr_mem_loader;
   localparam int ADDR_W    = 10;
   localparam int MAX_WORDS = 256;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [31:0]       d;
   } wr_t;

   logic              clk = 1'b0, rst = 1'b1, start = 1'b0, valid = 1'b0;
   logic [7:0]        data = '0;
   logic              ready, wr_en, cpu_rst, done, err;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   int                checks = 0, errors = 0;
   wr_t               exp_q[$];
   logic [31:0]       words[$];

   always #5 clk = ~clk;

   instr_mem_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .byte_valid_i(valid), .byte_data_i(data),
      .byte_ready_o(ready), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
      .cpu_rst_o(cpu_rst), .done_o(done), .err_o(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (wr_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write addr=%h data=%h at %0t", wr_addr, wr_data, $time);
         end else begin
            e = exp_q.pop_front();
            chk("write_addr", 32'(wr_addr), 32'(e.a));
            chk("write_data", wr_data, e.d);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_wr_en"}, 32'(wr_en), 0);
      chk({tag, "_wr_addr"}, 32'(wr_addr), 0);
      chk({tag, "_wr_data"}, wr_data, 0);
      chk({tag, "_cpu_rst"}, 32'(cpu_rst), 1);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_err"}, 32'(err), 0);
      chk({tag, "_ready"}, 32'(ready), 0);
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      chk("start_ready", 32'(ready), 1);
      chk("start_cpu_rst", 32'(cpu_rst), 1);
      chk("start_done", 32'(done), 0);
      chk("start_err", 32'(err), 0);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gmax);
      int n;
      repeat ($urandom_range(gmax, 0)) begin
         @(negedge clk);
         valid = 1'b0;
         data  = 8'($urandom);
      end
      @(negedge clk);
      valid = 1'b1;
      data  = b;
      n = 0;
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         checks++;
         errors++;
         $display("FAIL byte_timeout byte=%h ready=%b expected=1", b, ready);
      end
      @(posedge clk);
      #1 valid = 1'b0;
   endtask

   // reference: word i lands at byte address 4*i; checksum is XOR of payload bytes
   task automatic load(input int n, input bit bad, input int gmax, input int mid_start, input int abort_after);
      logic [7:0] cs, b;
      int cnt;
      wr_t w;
      cs  = '0;
      cnt = 0;
      pulse_start();
      send_byte(8'(n >> 8), gmax);
      send_byte(8'(n), gmax);
      if (n > MAX_WORDS) begin
         chk("oversize_err", 32'(err), 1);
         chk("oversize_ready", 32'(ready), 0);
         chk("oversize_cpu_rst", 32'(cpu_rst), 1);
         valid = 1'b1;
         repeat (3) begin
            @(negedge clk);
            chk("err_hold_ready", 32'(ready), 0);
         end
         valid = 1'b0;
         chk("err_hold", 32'(err), 1);
         return;
      end
      for (int i = 0; i < n; i++) begin
         for (int j = 0; j < 4; j++) begin
            b = words[i][31 - 8*j -: 8];
            cs ^= b;
            if (cnt == mid_start) begin
               @(negedge clk) start = 1'b1;
               @(negedge clk) start = 1'b0;
            end
            if (j == 3) begin
               w.a = ADDR_W'(4 * i);
               w.d = words[i];
               exp_q.push_back(w);
            end
            send_byte(b, gmax);
            cnt++;
            if (cnt == abort_after) begin
               @(negedge clk) rst = 1'b1;
               @(posedge clk);
               #1 check_reset_outputs("midload_rst");
               rst = 1'b0;
               return;
            end
         end
      end
      send_byte(bad ? cs ^ 8'h01 : cs, gmax);
      chk("result_done", 32'(done), 32'(!bad));
      chk("result_err", 32'(err), 32'(bad));
      chk("result_cpu_rst", 32'(cpu_rst), 32'(bad));
      chk("result_ready", 32'(ready), 0);
      repeat (2) @(negedge clk);
      chk("writes_drained", exp_q.size(), 0);
   endtask

   task automatic nominal_words();
      words = {32'h2008_0005, 32'h0000_0000};
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reset_outputs("reset");
      nominal_words();
      load(2, 0, 0, -1, -1);
      load(2, 1, 0, -1, -1);
      load(257, 0, 0, -1, -1);
      load(0, 0, 0, -1, -1);
      load(2, 0, 3, 3, -1);
      load(2, 0, 0, -1, 5);
      load(2, 0, 1, -1, -1);
      for (int k = 0; k < 10; k++) begin
         n = (k == 4) ? int'($urandom_range(65535, 257)) : int'($urandom_range(6, 0));
         words = {};
         for (int i = 0; i < n && i <= MAX_WORDS; i++) words.push_back($urandom);
         load(n, 1'($urandom), 2, int'($urandom_range(8, 0)), -1);
      end
      repeat (4) @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
